// File: rtl/sram_arbiter_pkg.sv
// Shared widths and response-tag layout for the Data/Inst SRAM arbiter.
package sram_arbiter_pkg;

   localparam int SRAM_ADDR_WD = 32;
   localparam int SRAM_DATA_WD = 32;
   localparam int SRAM_STRB_WD = SRAM_DATA_WD / 8;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   typedef struct packed {
      logic vld;
      logic owner;
      logic is_store;
   } resp_tag_t;

   localparam resp_tag_t RESP_IDLE = '{vld: 1'b0, owner: OWNER_INST, is_store: 1'b0};

endpackage

// File: rtl/sram_resp_pipe.sv
// Fixed-latency shift register of response tags, one stage per SRAM read cycle.
// Never stalls: a tag issued in cycle N appears on resp_tag in cycle N+RAM_LAT.
module sram_resp_pipe
   import sram_arbiter_pkg::*;
#(
   parameter int RAM_LAT = 1
)(
   input  logic      clk,
   input  logic      reset,
   input  resp_tag_t issue_tag,
   output resp_tag_t resp_tag
);

   resp_tag_t stage [RAM_LAT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) stage[i] <= RESP_IDLE;
      end else begin
         stage[0] <= issue_tag;
         for (int i = 1; i < RAM_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign resp_tag = stage[RAM_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch and data requesters; data_ok RAM_LAT cycles after addr_ok.
// Losing requester holds until addr_ok; responses are never back-pressured.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int RAM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inst_req,
   input  logic [SRAM_ADDR_WD-1:0] inst_addr,
   output logic                    inst_addr_ok,
   output logic                    inst_data_ok,
   output logic [SRAM_DATA_WD-1:0] inst_rdata,
   input  logic                    data_req,
   input  logic [SRAM_STRB_WD-1:0] data_wstrb,
   input  logic [SRAM_ADDR_WD-1:0] data_addr,
   input  logic [SRAM_DATA_WD-1:0] data_wdata,
   output logic                    data_addr_ok,
   output logic                    data_data_ok,
   output logic [SRAM_DATA_WD-1:0] data_rdata,
   output logic                    ram_en,
   output logic [SRAM_STRB_WD-1:0] ram_w_en,
   output logic [SRAM_ADDR_WD-1:0] ram_addr,
   output logic [SRAM_DATA_WD-1:0] ram_w_data,
   input  logic [SRAM_DATA_WD-1:0] ram_r_data
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]              starve_cnt;
   logic                    force_inst;
   logic                    grant_inst;
   logic                    grant_data;
   logic [SRAM_ADDR_WD-1:0] sel_addr;
   resp_tag_t               issue_tag;
   resp_tag_t               resp_tag;

   // Data wins by default; a fetch that has lost LIMIT cycles in a row is forced through.
   always_comb begin
      force_inst = inst_req & (starve_cnt == LIMIT);
      grant_data = data_req & ~force_inst & ~reset;
      grant_inst = inst_req & ~grant_data & ~reset;
   end

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;

   assign ram_en     = grant_inst | grant_data;
   assign sel_addr   = grant_data ? data_addr : (grant_inst ? inst_addr : '0);
   assign ram_addr   = sel_addr & {{(SRAM_ADDR_WD-2){1'b1}}, 2'b00};
   assign ram_w_en   = grant_data ? data_wstrb : '0;
   assign ram_w_data = ram_en ? data_wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (~inst_req | grant_inst) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign issue_tag = '{vld:      ram_en,
                        owner:    grant_data,
                        is_store: (|data_wstrb) & grant_data};

   sram_resp_pipe #(
      .RAM_LAT (RAM_LAT)
   ) u_resp_pipe (
      .clk       (clk),
      .reset     (reset),
      .issue_tag (issue_tag),
      .resp_tag  (resp_tag)
   );

   assign inst_data_ok = resp_tag.vld & (resp_tag.owner == OWNER_INST);
   assign data_data_ok = resp_tag.vld & (resp_tag.owner == OWNER_DATA);
   assign inst_rdata   = inst_data_ok ? ram_r_data : '0;
   assign data_rdata   = (data_data_ok & ~resp_tag.is_store) ? ram_r_data : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (RAM_LAT 1 and 3) share stimulus, each with its own SRAM model.
// A reference model pushes expected responses to per-instance queues; outputs are sampled on negedge.
module tb_sram_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        data_req;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;

   logic        inst_addr_ok [2];
   logic        inst_data_ok [2];
   logic [31:0] inst_rdata   [2];
   logic        data_addr_ok [2];
   logic        data_data_ok [2];
   logic [31:0] data_rdata   [2];
   logic        ram_en       [2];
   logic [3:0]  ram_w_en     [2];
   logic [31:0] ram_addr     [2];
   logic [31:0] ram_w_data   [2];
   logic [31:0] ram_r_data   [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.RAM_LAT(1), .STARVE_LIMIT(LIMIT)) u_lat1 (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok[0]),
      .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
      .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
      .ram_en(ram_en[0]), .ram_w_en(ram_w_en[0]), .ram_addr(ram_addr[0]),
      .ram_w_data(ram_w_data[0]), .ram_r_data(ram_r_data[0])
   );

   sram_arbiter #(.RAM_LAT(3), .STARVE_LIMIT(LIMIT)) u_lat3 (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok[1]),
      .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
      .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
      .ram_en(ram_en[1]), .ram_w_en(ram_w_en[1]), .ram_addr(ram_addr[1]),
      .ram_w_data(ram_w_data[1]), .ram_r_data(ram_r_data[1])
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic check_dat(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // SRAM models: fixed read latency, byte-write, word index from addr[11:2].
   logic [31:0] mem     [2][1024];
   logic [31:0] rd_pipe [2][4];
   bit          mem_init_done;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) begin
            mem[0][i] <= init_val(i);
            mem[1][i] <= init_val(i);
         end
         mem_init_done <= 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            rd_pipe[k][0] <= mem[k][ram_addr[k][11:2]];
            for (int s = 1; s < 4; s++) rd_pipe[k][s] <= rd_pipe[k][s-1];
            if (ram_en[k]) begin
               for (int b = 0; b < 4; b++)
                  if (ram_w_en[k][b]) mem[k][ram_addr[k][11:2]][8*b +: 8] <= ram_w_data[k][8*b +: 8];
            end
         end
      end
   end

   assign ram_r_data[0] = rd_pipe[0][0];
   assign ram_r_data[1] = rd_pipe[1][2];

   // Reference model and scoreboard.
   typedef struct {
      int          due;
      logic        owner;
      logic        is_store;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb_q [2][$];
   logic [31:0] ref_mem [1024];
   int          cyc;
   int          m_starve;
   logic        m_force, m_gd, m_gi, m_st;
   logic [31:0] m_addr, m_rd;
   logic        e_iok, e_dok;
   logic [31:0] e_ird, e_drd;
   exp_t        e;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      cyc = 0;
      m_starve = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            m_starve = 0;
            for (int k = 0; k < 2; k++) begin
               sb_q[k].delete();
               check_dat($sformatf("rst_inst_addr_ok%0d", k), 32'(inst_addr_ok[k]), 32'd0);
               check_dat($sformatf("rst_data_addr_ok%0d", k), 32'(data_addr_ok[k]), 32'd0);
               check_dat($sformatf("rst_ram_en%0d", k), 32'(ram_en[k]), 32'd0);
               check_dat($sformatf("rst_ram_w_en%0d", k), 32'(ram_w_en[k]), 32'd0);
               check_dat($sformatf("rst_inst_data_ok%0d", k), 32'(inst_data_ok[k]), 32'd0);
               check_dat($sformatf("rst_data_data_ok%0d", k), 32'(data_data_ok[k]), 32'd0);
            end
         end else begin
            m_force = inst_req && (m_starve == LIMIT);
            m_gd    = data_req && !m_force;
            m_gi    = inst_req && !m_gd;
            m_addr  = m_gd ? {data_addr[31:2], 2'b00} : (m_gi ? {inst_addr[31:2], 2'b00} : 32'd0);
            for (int k = 0; k < 2; k++) begin
               check_dat($sformatf("inst_addr_ok%0d", k), 32'(inst_addr_ok[k]), 32'(m_gi));
               check_dat($sformatf("data_addr_ok%0d", k), 32'(data_addr_ok[k]), 32'(m_gd));
               check_dat($sformatf("ram_en%0d", k), 32'(ram_en[k]), 32'(m_gi | m_gd));
               check_dat($sformatf("ram_addr%0d", k), ram_addr[k], m_addr);
               check_dat($sformatf("ram_w_en%0d", k), 32'(ram_w_en[k]), m_gd ? 32'(data_wstrb) : 32'd0);
               if (!m_gi) check_dat($sformatf("ram_w_data%0d", k), ram_w_data[k], m_gd ? data_wdata : 32'd0);
               e_iok = 1'b0; e_dok = 1'b0; e_ird = 32'd0; e_drd = 32'd0;
               if (sb_q[k].size() > 0 && sb_q[k][0].due == cyc) begin
                  e = sb_q[k].pop_front();
                  e_iok = !e.owner;
                  e_dok = e.owner;
                  if (e.owner) e_drd = e.is_store ? 32'd0 : e.rdata;
                  else         e_ird = e.rdata;
               end
               check_dat($sformatf("inst_data_ok%0d", k), 32'(inst_data_ok[k]), 32'(e_iok));
               check_dat($sformatf("inst_rdata%0d", k), inst_rdata[k], e_ird);
               check_dat($sformatf("data_data_ok%0d", k), 32'(data_data_ok[k]), 32'(e_dok));
               check_dat($sformatf("data_rdata%0d", k), data_rdata[k], e_drd);
               check_dat($sformatf("both_ok%0d", k), 32'(inst_data_ok[k] & data_data_ok[k]), 32'd0);
            end
            if (m_gi || m_gd) begin
               m_rd = ref_mem[m_addr[11:2]];
               m_st = m_gd && (data_wstrb != 4'h0);
               for (int k = 0; k < 2; k++)
                  sb_q[k].push_back('{due: cyc + lat_of(k), owner: m_gd, is_store: m_st, rdata: m_rd});
               if (m_st)
                  for (int b = 0; b < 4; b++)
                     if (data_wstrb[b]) ref_mem[m_addr[11:2]][8*b +: 8] = data_wdata[8*b +: 8];
            end
            if (!inst_req || m_gi) m_starve = 0;
            else if (m_starve != LIMIT) m_starve = m_starve + 1;
         end
      end
   end

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [3:0] ws,
                        input logic [31:0] da, input logic [31:0] wd, input int n);
      inst_req = ir; inst_addr = ia;
      data_req = dr; data_wstrb = ws; data_addr = da; data_wdata = wd;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [9:0] gseq;
   logic       ig, dg;

   initial begin
      reset = 1'b1;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      drive(0, 0, 0, 4'h0, 0, 0, 2);

      // Seed a word, then fetch it back.
      drive(0, 0, 1, 4'hF, 32'h1C000004, 32'h12345678, 1);
      drive(0, 0, 0, 4'h0, 0, 0, 1);
      drive(1, 32'h1C000004, 0, 4'h0, 0, 0, 1);
      drive(0, 0, 0, 4'h0, 0, 0, 0);
      @(negedge clk);
      check_dat("fetch_rdata", inst_rdata[0], 32'h12345678);
      @(posedge clk); #1;
      drive(0, 0, 0, 4'h0, 0, 0, 3);

      // Byte-lane store on an unaligned address, then load the word.
      inst_req = 0; data_req = 1; data_wstrb = 4'b0100; data_addr = 32'h00000102; data_wdata = 32'h00AB0000;
      @(negedge clk);
      check_dat("store_ram_addr", ram_addr[0], 32'h00000100);
      @(posedge clk); #1;
      drive(0, 0, 1, 4'h0, 32'h00000100, 0, 1);
      drive(0, 0, 0, 4'h0, 0, 0, 4);

      // Back-to-back fetch then load.
      drive(0, 0, 1, 4'hF, 32'h00000200, 32'hAAAA0000, 1);
      drive(0, 0, 1, 4'hF, 32'h00000300, 32'hBBBB0000, 1);
      drive(1, 32'h00000200, 0, 4'h0, 0, 0, 0);
      @(negedge clk); @(posedge clk); #1;
      drive(0, 0, 1, 4'h0, 32'h00000300, 0, 0);
      @(negedge clk);
      check_dat("mixed_inst_rdata", inst_rdata[0], 32'hAAAA0000);
      @(posedge clk); #1;
      drive(0, 0, 0, 4'h0, 0, 0, 0);
      @(negedge clk);
      check_dat("mixed_data_rdata", data_rdata[0], 32'hBBBB0000);
      @(posedge clk); #1;
      drive(0, 0, 0, 4'h0, 0, 0, 4);

      // Continuous contention.
      inst_req = 1; inst_addr = 32'h1C000004;
      data_req = 1; data_wstrb = 4'h0; data_addr = 32'h00000300;
      gseq = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         gseq = {gseq[8:0], data_addr_ok[0]};
         @(posedge clk); #1;
      end
      check_dat("grant_seq", 32'(gseq), 32'h3DE);
      drive(0, 0, 0, 4'h0, 0, 0, 5);

      // Single load after idle cycles for the latency sweep.
      drive(0, 0, 1, 4'h0, 32'h00000100, 0, 1);
      drive(0, 0, 0, 4'h0, 0, 0, 5);

      // Random traffic, payload held until accepted.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ig = inst_addr_ok[0];
         dg = data_addr_ok[0];
         @(posedge clk); #1;
         if (!inst_req || ig) begin
            inst_req  = 1'($urandom_range(0, 1));
            inst_addr = 32'h1C000000 | 32'($urandom_range(0, 4095));
         end
         if (!data_req || dg) begin
            data_req   = 1'($urandom_range(0, 1));
            data_addr  = 32'($urandom_range(0, 4095));
            data_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            data_wdata = $urandom;
         end
      end
      drive(0, 0, 0, 4'h0, 0, 0, 5);

      // Reset asserted between edges with a load in flight.
      drive(1, 32'h1C000004, 1, 4'h0, 32'h00000300, 0, 1);
      #1;
      check_dat("inflight_before_rst", 32'(data_data_ok[0]), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_dat("rst_async_data_ok", 32'(data_data_ok[0]), 32'd0);
      check_dat("rst_async_addr_ok", 32'(data_addr_ok[0] | inst_addr_ok[0]), 32'd0);
      check_dat("rst_async_ram_en", 32'(ram_en[0] | ram_en[1]), 32'd0);
      check_dat("rst_starve1", 32'(u_lat1.starve_cnt), 32'd0);
      check_dat("rst_starve3", 32'(u_lat3.starve_cnt), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1, 32'h1C000004, 0, 4'h0, 0, 0, 0);
      @(negedge clk);
      check_dat("post_rst_fetch_grant", 32'(inst_addr_ok[0]), 32'd1);
      @(posedge clk); #1;
      drive(0, 0, 0, 4'h0, 0, 0, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
